uart_rx_fifo: RTL

//  Receive-side elastic buffer between the osdvu uart receiver and its consumers (monitor state machine, cpu).

---
 rtl/uart_rx_fifo_pkg.sv | 13 +
 rtl/uart_rx_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the uart receive FIFO.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_WIDTH   = 8;
  localparam int unsigned RXFIFO_DEPTH_LOG2 = 4;
  localparam int unsigned ERR_COUNT_WIDTH   = 8;

  // Saturating increment for the receive-error counter.
  function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + ERR_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module uart_rx_fifo_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer for the uart: FWFT byte FIFO with occupancy,
// sticky overflow and a saturating framing-error count.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = RXFIFO_DEPTH_LOG2,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       received,
  input  logic [DATA_WIDTH-1:0]      rx_byte,
  input  logic                       recv_error,
  input  logic                       clear,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [DEPTH_LOG2:0]        count,
  output logic                       overflow,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  empty;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  drop;

  // Flags come only from the registered pointers; the extra MSB separates full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                    (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = !empty;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop_ok  = pop && !empty;
  assign push_ok = received && (!full || pop_ok);
  assign drop    = received && full && !pop_ok;

  uart_rx_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !clear),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (rx_byte),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (mem_rdata)
  );

  // Empty FIFO reads as zero so stale memory never shows after reset or clear.
  assign rd_data = rd_valid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push_ok)    wr_ptr    <= wr_ptr + PTR_W'(1);
      if (pop_ok)     rd_ptr    <= rd_ptr + PTR_W'(1);
      if (drop)       overflow  <= 1'b1;
      if (recv_error) err_count <= sat_inc(err_count);
    end
  end

endmodule
